// File: rtl/add_seq_pkg.sv
// Shared types and helpers for the sequential slice adder (add_seq_ctrl).
// Holds the FSM state enum, the fixed slice width, the slice-index width
// function and the 4-bit ripple primitive used by the carry-select slice.
package add_seq_pkg;

    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the slice index; never zero so a 1-bit index still exists.
    function automatic int idx_w(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

    // 4-bit ripple-carry adder, returns {cout, sum}.
    function automatic logic [4:0] rca4(input logic [3:0] a,
                                        input logic [3:0] b,
                                        input logic       ci);
        logic [4:0] r;
        logic       c;
        r = '0;
        c = ci;
        for (int i = 0; i < 4; i++) begin
            r[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        r[4] = c;
        return r;
    endfunction

endpackage

// File: rtl/csa_slice16.sv
// Combinational 16-bit carry-select adder.
// Each nibble computes its sum for carry-in 0 and 1 with a pair of 4-bit
// ripple adders; the incoming carry then selects one result per nibble.
module csa_slice16
    import add_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    localparam int NIB = SLICE_W / 4;

    logic [NIB:0]       c;
    logic [SLICE_W-1:0] sum0;
    logic [SLICE_W-1:0] sum1;
    logic [NIB-1:0]     co0;
    logic [NIB-1:0]     co1;

    assign c[0] = cin;

    // Per nibble: precompute both carry hypotheses, then select on the real carry.
    for (genvar g = 0; g < NIB; g++) begin : g_nib
        assign {co0[g], sum0[4*g +: 4]} = rca4(a[4*g +: 4], b[4*g +: 4], 1'b0);
        assign {co1[g], sum1[4*g +: 4]} = rca4(a[4*g +: 4], b[4*g +: 4], 1'b1);
        assign sum[4*g +: 4]            = c[g] ? sum1[4*g +: 4] : sum0[4*g +: 4];
        assign c[g+1]                   = c[g] ? co1[g] : co0[g];
    end

    assign cout = c[NIB];

endmodule

// File: rtl/add_seq_ctrl.sv
// Sequential wide adder: one shared 16-bit carry-select slice processes the
// operands one slice per cycle, least-significant slice first.
// Optional feature macro: ADD_SEQ_SUB_EN adds the in_sub port; when set at
// accept, B is inverted and the carry-in forced to 1 (cout=1 means no borrow).
//
// state | meaning
// IDLE  | ready for operands, in_ready=1
// RUN   | adding slice[idx] each cycle, carry held in carry_q
// DONE  | result valid, held until out_ready
module add_seq_ctrl #(
    parameter int NSLICE  = 4,
    parameter int SLICE_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NSLICE*SLICE_W-1:0] in_a,
    input  logic [NSLICE*SLICE_W-1:0] in_b,
    input  logic                      in_cin,
`ifdef ADD_SEQ_SUB_EN
    input  logic                      in_sub,
`endif
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NSLICE*SLICE_W-1:0] out_sum,
    output logic                      out_cout,
    output logic                      busy
);

    import add_seq_pkg::*;

    localparam int IW = idx_w(NSLICE);
    localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

    state_t                    state;
    logic [IW-1:0]             idx;
    logic                      carry_q;
    logic [NSLICE*SLICE_W-1:0] a_reg;
    logic [NSLICE*SLICE_W-1:0] b_reg;
    logic [SLICE_W-1:0]        slice_sum;
    logic                      slice_cout;

    csa_slice16 u_slice (
        .a    (a_reg[idx*SLICE_W +: SLICE_W]),
        .b    (b_reg[idx*SLICE_W +: SLICE_W]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Sequencer FSM with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            carry_q   <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= in_a;
`ifdef ADD_SEQ_SUB_EN
                        b_reg   <= in_sub ? ~in_b : in_b;
                        carry_q <= in_sub ? 1'b1 : in_cin;
`else
                        b_reg   <= in_b;
                        carry_q <= in_cin;
`endif
                        idx      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    out_sum[idx*SLICE_W +: SLICE_W] <= slice_sum;
                    carry_q <= slice_cout;
                    idx     <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state     <= DONE;
                        out_cout  <= slice_cout;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // Returning to IDLE here means the next accept is a cycle later.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Self-checking bench for add_seq_ctrl: directed corner cases plus a
// randomized back-to-back run checked against a whole-word arithmetic model.
// Build with ADD_SEQ_SUB_EN defined to also exercise subtraction.
module tb_add_seq_ctrl;

    localparam int NSLICE = 4;
    localparam int W      = NSLICE * 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         sub_drv;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    add_seq_ctrl #(.NSLICE(NSLICE), .SLICE_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef ADD_SEQ_SUB_EN
        .in_sub    (sub_drv),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Whole-word reference: {cout, sum} of an add, or of a - b offset by 2^W
    // so that cout=1 means no borrow.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
        logic [W:0] one_w;
        one_w = (W+1)'(1);
        if (sub)
            return {1'b0, a} + (one_w << W) - {1'b0, b};
        else
            return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operation, wait for out_valid, check latency and result.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub,
                          input logic [W-1:0] exp_sum, input logic exp_cout);
        int n;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        sub_drv  = sub;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_busy"}, busy, 1);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, NSLICE);
        check({tag, "_sum"}, out_sum, exp_sum);
        check({tag, "_cout"}, out_cout, exp_cout);
    endtask

    task automatic finish_op(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_vld_low"}, out_valid, 0);
        check({tag, "_rdy_back"}, in_ready, 1);
    endtask

    initial begin
        logic [W:0]   exp;
        logic [W:0]   q_exp[$];
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           pushed;
        int           got;
        int           cyc;
        int           last;
        int           vld_seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        sub_drv   = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", out_sum, 0);
        check("rst_cout", out_cout, 0);

        run_op("carry_into_slice1", 64'h1, 64'hFFFF, 1'b0, 1'b0, 64'h1_0000, 1'b0);
        finish_op("carry_into_slice1");

        run_op("full_ripple", {W{1'b1}}, '0, 1'b1, 1'b0, '0, 1'b1);
        finish_op("full_ripple");

        // Result held under backpressure while a new request is presented.
        exp = model(64'h1234_5678_9ABC_DEF0, 64'hF0F0_0F0F_1111_2222, 1'b1, 1'b0);
        run_op("hold", 64'h1234_5678_9ABC_DEF0, 64'hF0F0_0F0F_1111_2222, 1'b1, 1'b0,
               exp[W-1:0], exp[W]);
        in_a     = 64'hDEAD_BEEF_0000_0001;
        in_b     = 64'h0000_0000_0000_0003;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_sum", out_sum, exp[W-1:0]);
            check("hold_cout", out_cout, exp[W]);
            check("hold_in_ready", in_ready, 0);
            check("hold_out_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        finish_op("hold");
        check("hold_no_accept", busy, 0);

        // Abort mid-operation: no result may appear afterwards.
        in_a     = 64'h1111_2222_3333_4444;
        in_b     = 64'h5555_6666_7777_8888;
        in_cin   = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_sum", out_sum, 0);
        vld_seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) vld_seen++;
            tick();
        end
        check("abort_no_result", vld_seen, 0);
        run_op("after_abort", 64'd5, 64'd7, 1'b0, 1'b0, 64'd12, 1'b0);
        finish_op("after_abort");

        // Reset wins over a simultaneous accept request.
        in_valid = 1'b1;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rst_prio_busy", busy, 0);
        check("rst_prio_in_ready", in_ready, 1);

        // Reset in DONE while the consumer is ready.
        run_op("done_rst", 64'hFFFF, 64'h1, 1'b0, 1'b0, 64'h1_0000, 1'b0);
        out_ready = 1'b1;
        rst       = 1'b1;
        tick();
        rst       = 1'b0;
        out_ready = 1'b0;
        check("done_rst_vld", out_valid, 0);
        check("done_rst_cout", out_cout, 0);

`ifdef ADD_SEQ_SUB_EN
        run_op("sub_borrow", 64'd3, 64'd5, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        finish_op("sub_borrow");
        run_op("sub_ok", 64'd5, 64'd3, 1'b1, 1'b1, 64'd2, 1'b1);
        finish_op("sub_ok");
`endif

        // Back-to-back random operations with the consumer always ready.
        pushed    = 0;
        got       = 0;
        cyc       = 0;
        last      = -1;
        out_ready = 1'b1;
        while (got < 1000 && cyc < 9000) begin
            if (out_valid) begin
                check("rnd_queue_nonempty", q_exp.size() > 0, 1);
                if (q_exp.size() > 0) begin
                    exp = q_exp.pop_front();
                    check("rnd_sum", out_sum, exp[W-1:0]);
                    check("rnd_cout", out_cout, exp[W]);
                end
                if (last >= 0) check("rnd_gap", cyc - last, NSLICE + 2);
                last = cyc;
                got++;
            end
            if (in_ready) begin
                if (pushed < 1000) begin
                    ra = {$urandom, $urandom};
                    rb = {$urandom, $urandom};
                    if ($urandom_range(0, 7) == 0) rb = ~ra;
                    in_a   = ra;
                    in_b   = rb;
                    in_cin = 1'($urandom_range(0, 1));
`ifdef ADD_SEQ_SUB_EN
                    sub_drv = 1'($urandom_range(0, 1));
`else
                    sub_drv = 1'b0;
`endif
                    in_valid = 1'b1;
                    q_exp.push_back(model(ra, rb, in_cin, sub_drv));
                    pushed++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("rnd_count", got, 1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
